// File: rtl/sipo_deserializer_if.sv
// Bus bundle for the SIPO deserializer: serial input side, parallel output
// handshake and status. master = the side driving the serial stream and
// consuming words; slave = the deserializer itself.
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 4
) ();

  localparam int unsigned CW = $clog2(WIDTH);

  logic             sin;
  logic             sin_valid;
  logic             sync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CW-1:0]    bit_cnt;
  logic             busy;
  logic             overflow;

  modport master (
    output sin, sin_valid, sync, dout_ready,
    input  dout, dout_valid, bit_cnt, busy, overflow
  );

  modport slave (
    input  sin, sin_valid, sync, dout_ready,
    output dout, dout_valid, bit_cnt, busy, overflow
  );

endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer with a one-word holding register,
// valid/ready output handshake, sync realignment and a sticky overflow flag.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  sipo_deserializer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;
  logic             complete;

  // Shift candidate and the lone-first-bit pattern used when sync restarts a word
  always_comb begin
    shifted   = '0;
    first_bit = '0;
    if (MSB_FIRST) begin
      shifted      = {shreg_q[WIDTH-2:0], bus.sin};
      first_bit[0] = bus.sin;
    end else begin
      shifted            = {bus.sin, shreg_q[WIDTH-1:1]};
      first_bit[WIDTH-1] = bus.sin;
    end
  end

  // sync on the would-be final bit cancels the completion
  assign complete = bus.sin_valid && (cnt_q == CntLast) && !bus.sync;

  // Next state for the shift register and bit counter
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (bus.sync) begin
      shreg_d = bus.sin_valid ? first_bit : '0;
      cnt_d   = bus.sin_valid ? CW'(1) : '0;
    end else if (bus.sin_valid) begin
      shreg_d = shifted;
      cnt_d   = complete ? '0 : cnt_q + CW'(1);
    end
  end

  // Next state for the holding register and overflow flag
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overflow_d   = overflow_q;
    if (complete) begin
      if (!dout_valid_q || bus.dout_ready) begin
        dout_d       = shifted;
        dout_valid_d = 1'b1;
      end else begin
        // Holding register stalled: drop the new word, keep the old one
        overflow_d = 1'b1;
      end
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.busy       = (cnt_q != '0);
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: one MSB-first and one LSB-first instance fed the
// same stream, checked against a bit-queue reference model.
module tb_sipo_deserializer;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W);
  localparam int unsigned SW = 2 * (3 + CW) + 2 * W;

  logic clk;
  logic rst;

  sipo_deserializer_if #(.WIDTH(W)) ifm ();
  sipo_deserializer_if #(.WIDTH(W)) ifl ();

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (ifm)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (ifl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: bits received toward the current word, plus holding state
  bit           q[$];
  logic         mv;
  logic         mo;
  logic [W-1:0] md_m;
  logic [W-1:0] md_l;

  task automatic drive(input logic s, input logic v, input logic sy, input logic rd);
    ifm.sin = s;  ifm.sin_valid = v;  ifm.sync = sy;  ifm.dout_ready = rd;
    ifl.sin = s;  ifl.sin_valid = v;  ifl.sync = sy;  ifl.dout_ready = rd;
  endtask

  task automatic model_step();
    logic [W-1:0] wm;
    logic [W-1:0] wl;
    bit           done;
    wm   = '0;
    wl   = '0;
    done = 1'b0;
    if (rst) begin
      q.delete();
      mv   = 1'b0;
      mo   = 1'b0;
      md_m = '0;
      md_l = '0;
    end else begin
      if (ifm.sync) q.delete();
      if (ifm.sin_valid) q.push_back(ifm.sin);
      if (q.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = q[i];
          wl[i]     = q[i];
        end
        q.delete();
      end
      if (done) begin
        if (!mv || ifm.dout_ready) begin
          mv   = 1'b1;
          md_m = wm;
          md_l = wl;
        end else begin
          mo = 1'b1;
        end
      end else if (mv && ifm.dout_ready) begin
        mv = 1'b0;
      end
    end
  endtask

  // One clock: model sees the same inputs the DUTs sample, then settle
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [SW-1:0] obs_vec();
    return {ifm.dout_valid, ifm.overflow, ifm.bit_cnt, ifm.busy,
            ifl.dout_valid, ifl.overflow, ifl.bit_cnt, ifl.busy,
            (mv ? ifm.dout : {W{1'b0}}), (mv ? ifl.dout : {W{1'b0}})};
  endfunction

  function automatic logic [SW-1:0] exp_vec();
    logic [CW-1:0] c;
    c = CW'(q.size());
    return {mv, mo, c, (q.size() != 0), mv, mo, c, (q.size() != 0),
            (mv ? md_m : {W{1'b0}}), (mv ? md_l : {W{1'b0}})};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    total++;
    if (obs_vec() !== exp_vec())
      $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
    else passed++;
    total++;
    if ({ifm.dout, ifm.dout_valid, ifm.bit_cnt, ifm.busy, ifm.overflow} !== '0)
      $display("FAIL reset_zero: got dout=%h v=%b cnt=%0d ovf=%b expected all 0",
               ifm.dout, ifm.dout_valid, ifm.bit_cnt, ifm.overflow);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    logic [CW-1:0] ec[4];
    bits = 4'b0101;
    ec[0] = 1; ec[1] = 2; ec[2] = 3; ec[3] = 0;
    for (int i = 0; i < 4; i++) begin
      drive(bits[3-i], 1'b1, 1'b0, 1'b1);
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL basic_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passed++;
      total++;
      if (ifm.bit_cnt !== ec[i])
        $display("FAIL basic_cnt%0d: got %0d expected %0d", i, ifm.bit_cnt, ec[i]);
      else passed++;
    end
    total++;
    if (!(ifm.dout_valid === 1'b1 && ifm.dout === 4'b0101 && ifm.overflow === 1'b0))
      $display("FAIL basic_word: got v=%b dout=%b expected v=1 dout=0101",
               ifm.dout_valid, ifm.dout);
    else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    total++;
    if (ifm.dout_valid !== 1'b0)
      $display("FAIL basic_one_cycle: got v=%b expected 0", ifm.dout_valid);
    else passed++;
  endtask

  task automatic test_lsb_gaps();
    logic [3:0] bits;
    bits = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      drive(bits[3-i], 1'b1, 1'b0, 1'b1);
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL lsb_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passed++;
      if (i == 1) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b1, 1'b0, 1'b0, 1'b1);
          tick();
          total++;
          if (ifl.bit_cnt !== CW'(2))
            $display("FAIL lsb_gap%0d: got cnt=%0d expected 2", g, ifl.bit_cnt);
          else passed++;
        end
      end
    end
    total++;
    if (!(ifl.dout_valid === 1'b1 && ifl.dout === 4'b0011))
      $display("FAIL lsb_word: got v=%b dout=%b expected v=1 dout=0011",
               ifl.dout_valid, ifl.dout);
    else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] bits;
    bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      drive(bits[7-i], 1'b1, 1'b0, 1'b0);
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL bp_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passed++;
      if (i >= 3) begin
        total++;
        if (!(ifm.dout_valid === 1'b1 && ifm.dout === 4'hA))
          $display("FAIL bp_hold%0d: got v=%b dout=%h expected v=1 dout=a",
                   i, ifm.dout_valid, ifm.dout);
        else passed++;
      end
    end
    total++;
    if (ifm.overflow !== 1'b1)
      $display("FAIL bp_overflow: got %b expected 1", ifm.overflow);
    else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    total++;
    if (!(ifm.dout_valid === 1'b0 && ifm.overflow === 1'b1))
      $display("FAIL bp_release: got v=%b ovf=%b expected v=0 ovf=1",
               ifm.dout_valid, ifm.overflow);
    else passed++;
  endtask

  task automatic test_read_complete();
    logic [7:0] bits;
    bits = 8'h3C;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(bits[7-i], 1'b1, 1'b0, (i == 7));
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL rc_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (!(ifm.dout_valid === 1'b1 && ifm.dout === 4'hC && ifm.overflow === 1'b0))
      $display("FAIL rc_word: got v=%b dout=%h ovf=%b expected v=1 dout=c ovf=0",
               ifm.dout_valid, ifm.dout, ifm.overflow);
    else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_sync();
    logic [5:0] bits;
    logic [5:0] sy;
    bits = 6'b101011;
    sy   = 6'b001000;
    for (int i = 0; i < 6; i++) begin
      drive(bits[5-i], 1'b1, sy[5-i], 1'b1);
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL sync_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passed++;
      if (i == 2) begin
        total++;
        if (!(ifm.bit_cnt === CW'(1) && ifm.dout_valid === 1'b0))
          $display("FAIL sync_cnt: got cnt=%0d v=%b expected cnt=1 v=0",
                   ifm.bit_cnt, ifm.dout_valid);
        else passed++;
      end
    end
    total++;
    if (!(ifm.dout_valid === 1'b1 && ifm.dout === 4'b1011))
      $display("FAIL sync_word: got v=%b dout=%b expected v=1 dout=1011",
               ifm.dout_valid, ifm.dout);
    else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] w;
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      tick();
    end
    total++;
    if (!(ifm.dout_valid === 1'b1 && ifm.bit_cnt === CW'(2)))
      $display("FAIL rmid_pre: got v=%b cnt=%0d expected v=1 cnt=2",
               ifm.dout_valid, ifm.bit_cnt);
    else passed++;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    total++;
    if ({ifm.dout, ifm.dout_valid, ifm.bit_cnt, ifm.busy, ifm.overflow,
         ifl.dout, ifl.dout_valid, ifl.bit_cnt, ifl.busy, ifl.overflow} !== '0)
      $display("FAIL rmid_zero: got m=%h/%b/%0d l=%h/%b/%0d expected all 0",
               ifm.dout, ifm.dout_valid, ifm.bit_cnt, ifl.dout, ifl.dout_valid, ifl.bit_cnt);
    else passed++;
    w = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      drive(w[3-i], 1'b1, 1'b0, 1'b1);
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL rmid_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (!(ifm.dout_valid === 1'b1 && ifm.dout === w))
      $display("FAIL rmid_word: got v=%b dout=%h expected v=1 dout=%h",
               ifm.dout_valid, ifm.dout, w);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1));
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random_cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    mv   = 1'b0;
    mo   = 1'b0;
    md_m = '0;
    md_l = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_lsb_gaps();
    test_backpressure();
    test_read_complete();
    test_sync();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
